// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - state/opcode-class encodings and RV32I opcode constants
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd7
  } state_e;

  // CLS_NONE doubles as the reset value and the "illegal opcode" marker
  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_ALU     = 4'd1,
    CLS_ALU_IMM = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_AUIPC   = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_LOAD    = 4'd8,
    CLS_STORE   = 4'd9
  } op_class_e;

  localparam logic [6:0] OP_ALU     = 7'h33;
  localparam logic [6:0] OP_ALU_IMM = 7'h13;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;

  function automatic op_class_e decode_class(input logic [6:0] op);
    case (op)
      OP_ALU:     decode_class = CLS_ALU;
      OP_ALU_IMM: decode_class = CLS_ALU_IMM;
      OP_LUI:     decode_class = CLS_LUI;
      OP_AUIPC:   decode_class = CLS_AUIPC;
      OP_JAL:     decode_class = CLS_JAL;
      OP_JALR:    decode_class = CLS_JALR;
      OP_BRANCH:  decode_class = CLS_BRANCH;
      OP_LOAD:    decode_class = CLS_LOAD;
      OP_STORE:   decode_class = CLS_STORE;
      default:    decode_class = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - sequencer control/handshake bundle
interface multicycle_sequencer_if #(
  parameter int RETIRE_W = 32
) ();
  logic [6:0]          opcode;
  logic                branchTaken;
  logic                imemReady;
  logic                dmemReady;
  logic                imemReq;
  logic                irWriteEn;
  logic                pcWriteEn;
  logic                pcSrcSel;
  logic                dmemReq;
  logic                dmemWe;
  logic                regWriteEn;
  logic                trap;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retireCount;

  modport master (
    input  opcode, branchTaken, imemReady, dmemReady,
    output imemReq, irWriteEn, pcWriteEn, pcSrcSel, dmemReq, dmemWe,
           regWriteEn, trap, state, retireCount
  );

  modport slave (
    output opcode, branchTaken, imemReady, dmemReady,
    input  imemReq, irWriteEn, pcWriteEn, pcSrcSel, dmemReq, dmemWe,
           regWriteEn, trap, state, retireCount
  );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// rtl/multicycle_sequencer_mem_wait_timer.sv - 4-bit memory wait counter shared by FETCH and MEM
module multicycle_sequencer_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam logic [3:0] LAST_CNT = 4'(MEM_TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = 4'd0;
    else if (en_i)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  // High during the last tolerated unanswered cycle; the FSM lets ready win
  assign timeout_o = (cnt_q == LAST_CNT);
endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);
  state_e              state_q, state_d;
  op_class_e           class_q, class_d;
  logic [RETIRE_W-1:0] retire_q;
  logic                retire;
  logic                timeout, wait_clr, wait_en;

  multicycle_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .timeout_o (timeout)
  );

  assign wait_clr = (state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM);
  assign wait_en  = (state_q == ST_FETCH && !bus.imemReady) ||
                    (state_q == ST_MEM   && !bus.dmemReady);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      class_q  <= CLS_NONE;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      if (retire)
        retire_q <= retire_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.imemReady)
          state_d = ST_DECODE;
        else if (timeout)
          state_d = ST_TRAP;
      end
      ST_DECODE: begin
        class_d = decode_class(bus.opcode);
        state_d = (class_d == CLS_NONE) ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_BRANCH:          state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.dmemReady)
          state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout)
          state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are decoded combinationally and forced low while rst is asserted
  always_comb begin
    bus.imemReq    = 1'b0;
    bus.irWriteEn  = 1'b0;
    bus.pcWriteEn  = 1'b0;
    bus.pcSrcSel   = 1'b0;
    bus.dmemReq    = 1'b0;
    bus.dmemWe     = 1'b0;
    bus.regWriteEn = 1'b0;
    bus.trap       = 1'b0;
    retire         = 1'b0;
    if (rst) begin
      case (state_q)
        ST_FETCH: begin
          bus.imemReq   = 1'b1;
          bus.irWriteEn = bus.imemReady;
        end
        ST_EXECUTE: begin
          if (class_q == CLS_BRANCH) begin
            bus.pcWriteEn = 1'b1;
            bus.pcSrcSel  = bus.branchTaken;
            retire        = 1'b1;
          end
        end
        ST_MEM: begin
          bus.dmemReq = 1'b1;
          bus.dmemWe  = (class_q == CLS_STORE);
          if (class_q == CLS_STORE && bus.dmemReady) begin
            bus.pcWriteEn = 1'b1;
            retire        = 1'b1;
          end
        end
        ST_WB: begin
          bus.regWriteEn = 1'b1;
          bus.pcWriteEn  = 1'b1;
          bus.pcSrcSel   = (class_q == CLS_JAL || class_q == CLS_JALR);
          retire         = 1'b1;
        end
        ST_TRAP: bus.trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.retireCount = retire_q;
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Control FSM that runs the RISC-V datapath as a multi-cycle machine instead of a single cycle per instruction.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Handles ready-based handshakes with instruction and data memory, and gates PC, IR and register-file writes.
- Sits beside the instruction decoder. The decoder supplies mux and ALU selects; this block supplies the timing: when each write enable fires and when memory is requested.

Parameters:
- MEM_TIMEOUT, 15: unanswered memory-request cycles tolerated before TRAP. Legal range 1-15; the wait counter is 4 bits.
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  inst[6:0] from the instruction register
- branchTaken  in  1  branch comparator result; valid in EXECUTE
- imemReady  in  1  instruction memory has data this cycle
- dmemReady  in  1  data memory has completed the access this cycle
- imemReq  out  1  instruction fetch request
- irWriteEn  out  1  load the instruction register
- pcWriteEn  out  1  update the PC
- pcSrcSel  out  1  0 = PC+4, 1 = computed target
- dmemReq  out  1  data memory request
- dmemWe  out  1  data memory write (store)
- regWriteEn  out  1  register file write
- trap  out  1  sticky fault indicator
- state  out  3  current state encoding, for debug
- retireCount  out  RETIRE_W  number of retired instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7. Codes 5 and 6 are unused and recover to FETCH.
- Reset, while rst=0:
  - state=FETCH, retireCount=0, wait counter=0, latched opcode class=0.
  - Every output except state is forced to 0, asynchronously.
  - First imemReq is asserted in the first cycle after rst rises.
- All outputs are Moore/Mealy-decoded from state, latched class and the ready inputs. No output is a separate register apart from retireCount and trap.
- FETCH:
  - imemReq=1 until imemReady.
  - The cycle imemReady=1: irWriteEn=1 for exactly that cycle; next state DECODE.
- DECODE (1 cycle):
  - Latch the opcode class: ALU, ALU_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
  - Any other opcode goes to TRAP; otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - BRANCH: pcWriteEn=1, pcSrcSel=branchTaken, retire; go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmemReq=1, and dmemWe=1 if the class is STORE; both held until dmemReady.
  - On dmemReady, LOAD goes to WB.
  - On dmemReady, STORE asserts pcWriteEn=1 and pcSrcSel=0, retires, and goes to FETCH.
- WB (1 cycle):
  - regWriteEn=1 and pcWriteEn=1.
  - pcSrcSel=1 for JAL/JALR, otherwise 0.
  - Retire; go to FETCH.
- Retire means retireCount+1. It wraps from all-ones to 0 with no flag.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle that the request is high and ready is low.
  - If ready is still low when the counter equals MEM_TIMEOUT-1, go to TRAP, i.e. after MEM_TIMEOUT unanswered cycles.
  - If ready arrives in the same cycle the timeout would fire, ready wins.
- TRAP:
  - All enables and requests are 0 and trap=1.
  - Stays in TRAP until reset; retireCount is frozen.
- Ready inputs are ignored outside their own state.
- Reset asserted mid-operation, e.g. during a MEM wait: outputs drop to 0 in the same cycle, any pending write is abandoned, and the machine restarts in FETCH.

Decomposition:
- The shared constants include file (const.v) gets:
  - the state encodings;
  - the opcode-class encodings;
  - the existing OP_* opcode defines.
- One natural sub-module is mem_wait_timer: the 4-bit wait counter with clear, count-enable and a timeout output, instantiated once and shared by FETCH and MEM.
- The rest is a single FSM.

Test Plan:
1. ADDI (opcode 0x13), imemReady=1 throughout -> state 0,1,2,4,0; regWriteEn and pcWriteEn high only in the WB cycle; pcSrcSel=0; retireCount=1.
2. LW (0x03), dmemReady raised on the 4th MEM cycle -> dmemReq high for 4 cycles, dmemWe=0, then WB with regWriteEn=1; 5 instructions in total give retireCount=5.
3. SW (0x23), dmemReady immediate -> one MEM cycle with dmemReq=1 and dmemWe=1, pcWriteEn=1 in that same cycle, regWriteEn never asserted.
4. BEQ (0x63) with branchTaken=1, then again with branchTaken=0 -> EXECUTE cycle shows pcWriteEn=1 with pcSrcSel=1 and then 0; no WB state; JAL (0x6F) gives pcSrcSel=1 in WB.
5. imemReady held at 0 -> imemReq high for exactly 15 cycles, then state=7 and trap=1; trap stays set after imemReady rises; reset clears it.
6. Opcode 0x00 -> TRAP directly from DECODE. Separately, rst dropped mid-MEM wait -> all outputs 0 in the same cycle, retireCount=0, and FETCH on release.
